// File: rtl/sprite_line_engine_pkg.sv
// Shared types for the sprite line engine: attribute layout, geometry constants, FSM states.
package sprite_line_engine_pkg;

  localparam int ATTR_W    = 27;
  localparam int POS_W     = 10;
  localparam int NUM_W     = 6;
  localparam int ROW_W     = 3;
  localparam int COL_W     = 3;
  localparam int PIX_W     = 2;
  localparam int LR_ADDR_W = 11;
  localparam int SPR_W     = 16;
  localparam int SPR_ROM_W = 8;

  // Packed MSB-first so it overlays the raw attribute word {en, num, y, x}.
  typedef struct packed {
    logic             en;
    logic [NUM_W-1:0] num;
    logic [POS_W-1:0] y;
    logic [POS_W-1:0] x;
  } attr_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_SCAN  = 3'd2,
    ST_DRAW  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  function automatic logic [POS_W-1:0] row_delta(input logic [POS_W-1:0] row,
                                                 input logic [POS_W-1:0] y);
    return row - y;
  endfunction

endpackage

// File: rtl/sprite_line_engine_if.sv
// Host-side bundle of the sprite line engine: line control, attribute port, ROM and line-RAM ports.
interface sprite_line_engine_if
  import sprite_line_engine_pkg::*;
#(
  parameter int NSPR = 16
);
  localparam int IW = $clog2(NSPR);

  logic                 i_Line_Start;
  logic [POS_W-1:0]     i_Next_Row;
  logic                 i_Attr_We;
  logic [IW-1:0]        i_Attr_Addr;
  logic [ATTR_W-1:0]    i_Attr_Data;
  logic [NUM_W-1:0]     o_Rom_Sprite;
  logic [ROW_W-1:0]     o_Rom_Row;
  logic [COL_W-1:0]     o_Rom_Col;
  logic [PIX_W-1:0]     i_Rom_Pixel;
  logic                 o_Lr_We;
  logic [LR_ADDR_W-1:0] o_Lr_Addr;
  logic [PIX_W-1:0]     o_Lr_Data;
  logic                 o_Busy;
  logic                 o_Overrun;

  modport master (
    output i_Line_Start, i_Next_Row, i_Attr_We, i_Attr_Addr, i_Attr_Data, i_Rom_Pixel,
    input  o_Rom_Sprite, o_Rom_Row, o_Rom_Col, o_Lr_We, o_Lr_Addr, o_Lr_Data, o_Busy, o_Overrun
  );

  modport slave (
    input  i_Line_Start, i_Next_Row, i_Attr_We, i_Attr_Addr, i_Attr_Data, i_Rom_Pixel,
    output o_Rom_Sprite, o_Rom_Row, o_Rom_Col, o_Lr_We, o_Lr_Addr, o_Lr_Data, o_Busy, o_Overrun
  );

endinterface

// File: rtl/sprite_line_engine_attr_table.sv
// Sprite attribute register file: synchronous write, asynchronous read, cleared on reset.
module sprite_line_engine_attr_table
  import sprite_line_engine_pkg::*;
#(
  parameter int NSPR = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    we_i,
  input  logic [$clog2(NSPR)-1:0] waddr_i,
  input  attr_t                   wdata_i,
  input  logic [$clog2(NSPR)-1:0] raddr_i,
  output attr_t                   rdata_o
);

  attr_t tbl_q [NSPR];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NSPR; i++) tbl_q[i] <= '0;
    end else if (we_i) begin
      tbl_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = tbl_q[raddr_i];

endmodule

// File: rtl/sprite_line_engine.sv
// Per-scanline sprite scheduler: clears the back line-RAM bank, then scans the attribute
// table from the highest index down and paints each hitting sprite through the ROM.
module sprite_line_engine
  import sprite_line_engine_pkg::*;
#(
  parameter int NSPR   = 16,
  parameter int LINE_W = 256
) (
  input  logic                i_Clk,
  input  logic                i_Reset,
  sprite_line_engine_if.slave bus
);

  localparam int IW = $clog2(NSPR);
  localparam int EW = $clog2(LINE_W);
  localparam logic [IW-1:0]    IDX_LAST  = IW'(NSPR - 1);
  localparam logic [EW-1:0]    CLR_LAST  = EW'(LINE_W - 1);
  localparam logic [POS_W-1:0] ENTRY_LIM = POS_W'(LINE_W);
  localparam logic [3:0]       COL_END   = 4'(SPR_ROM_W);

  state_e state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [EW-1:0] clr_q, clr_d;
  logic [3:0]    col_q, col_d;
  logic          busy_q, overrun_q;

  logic [POS_W-1:0] row_q;
  logic [NUM_W-1:0] num_q;
  logic [ROW_W-1:0] srow_q;
  logic [8:0]       sx_q;
  logic             wr_vld_p1_q;
  logic [EW-1:0]    wr_entry_p1_q;

  attr_t            scan_attr;
  logic [POS_W-1:0] scan_dy;
  logic             scan_hit;
  logic             accept;
  logic             issue;
  logic             bank;
  logic [POS_W-1:0] entry_w;
  logic             entry_ok;
  logic             unused_x0;

  sprite_line_engine_attr_table #(.NSPR(NSPR)) u_attr (
    .clk_i   (i_Clk),
    .rst_i   (i_Reset),
    .we_i    (bus.i_Attr_We),
    .waddr_i (bus.i_Attr_Addr),
    .wdata_i (attr_t'(bus.i_Attr_Data)),
    .raddr_i (idx_q),
    .rdata_o (scan_attr)
  );

  assign accept    = bus.i_Line_Start && (state_q == ST_IDLE) && !busy_q;
  assign bank      = row_q[1];
  assign scan_dy   = row_delta(row_q, scan_attr.y);
  assign scan_hit  = scan_attr.en && (scan_dy < POS_W'(SPR_W));
  assign issue     = (state_q == ST_DRAW) && (col_q != COL_END);
  // Entry kept wide so a sprite running off the right edge is clipped rather than wrapped.
  assign entry_w   = {2'b00, sx_q[7:0]} + {7'b0, col_q[2:0]};
  assign entry_ok  = !sx_q[8] && (entry_w < ENTRY_LIM);
  assign unused_x0 = scan_attr.x[0];

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    clr_d   = clr_q;
    col_d   = col_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_CLEAR;
          clr_d   = '0;
          idx_d   = IDX_LAST;
        end
      end
      ST_CLEAR: begin
        clr_d = clr_q + 1'b1;
        if (clr_q == CLR_LAST) state_d = ST_SCAN;
      end
      ST_SCAN: begin
        if (scan_hit) begin
          state_d = ST_DRAW;
          col_d   = '0;
        end else if (idx_q == '0) begin
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      ST_DRAW: begin
        col_d = col_q + 4'd1;
        if (col_q == COL_END) begin
          if (idx_q == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_SCAN;
            idx_d   = idx_q - 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      clr_q       <= '0;
      col_q       <= '0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
      wr_vld_p1_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      clr_q       <= clr_d;
      col_q       <= col_d;
      busy_q      <= accept || (state_q != ST_IDLE);
      overrun_q   <= overrun_q || (bus.i_Line_Start && busy_q);
      wr_vld_p1_q <= issue && entry_ok;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (accept) row_q <= bus.i_Next_Row;
    if (state_q == ST_SCAN) begin
      num_q  <= scan_attr.num;
      srow_q <= scan_dy[3:1];
      sx_q   <= scan_attr.x[9:1];
    end
    // ROM address stage -> write stage: entry travels alongside the ROM's 1-cycle latency.
    wr_entry_p1_q <= entry_w[EW-1:0];
  end

  always_comb begin
    bus.o_Rom_Sprite = '0;
    bus.o_Rom_Row    = '0;
    bus.o_Rom_Col    = '0;
    bus.o_Lr_We      = 1'b0;
    bus.o_Lr_Addr    = '0;
    bus.o_Lr_Data    = '0;
    if (issue) begin
      bus.o_Rom_Sprite = num_q;
      bus.o_Rom_Row    = srow_q;
      bus.o_Rom_Col    = col_q[2:0];
    end
    if (state_q == ST_CLEAR) begin
      bus.o_Lr_We   = 1'b1;
      bus.o_Lr_Addr = LR_ADDR_W'({bank, clr_q});
    end else if (wr_vld_p1_q) begin
      bus.o_Lr_We   = (bus.i_Rom_Pixel != '0);
      bus.o_Lr_Addr = LR_ADDR_W'({bank, wr_entry_p1_q});
      bus.o_Lr_Data = bus.i_Rom_Pixel;
    end
  end

  assign bus.o_Busy    = busy_q;
  assign bus.o_Overrun = overrun_q;

endmodule

// File: tb/tb_sprite_line_engine.sv
// Scoreboard bench for sprite_line_engine: a line-level reference model predicts every
// line-RAM write and the final bank contents; a monitor checks writes as they appear.
module tb_sprite_line_engine;
  localparam int NSPR   = 16;
  localparam int LINE_W = 256;
  localparam int IW     = $clog2(NSPR);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sprite_line_engine_if #(.NSPR(NSPR)) bus ();

  sprite_line_engine #(.NSPR(NSPR), .LINE_W(LINE_W)) dut (
    .i_Clk   (clk),
    .i_Reset (rst),
    .bus     (bus)
  );

  logic [26:0] model_attr [NSPR];
  logic [1:0]  rom_mem    [64][8][8];
  logic [1:0]  lr_mem     [2048];
  logic [1:0]  model_buf  [LINE_W];
  logic [12:0] exp_q [$];
  int n_tests = 0;
  int n_fail  = 0;

  // Sprite ROM with one cycle of read latency.
  always @(posedge clk)
    bus.i_Rom_Pixel <= rom_mem[bus.o_Rom_Sprite][bus.o_Rom_Row][bus.o_Rom_Col];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [26:0] mk(input logic en, input logic [5:0] num,
                                     input logic [9:0] y, input logic [9:0] x);
    return {en, num, y, x};
  endfunction

  task automatic monitor();
    logic [12:0] e;
    int a;
    forever begin
      @(negedge clk);
      if (bus.o_Lr_We) begin
        a = int'(bus.o_Lr_Addr);
        lr_mem[a] = bus.o_Lr_Data;
        if (exp_q.size() == 0) begin
          chk("unexpected_write_addr", a, -1);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", a, int'(e[12:2]));
          chk("wr_data", int'(bus.o_Lr_Data), int'(e[1:0]));
        end
      end
    end
  endtask

  // Line-level model: clear the bank, then paint hitting sprites from high index to low.
  task automatic build_expect(input logic [9:0] row, output int hits);
    logic        bk;
    logic [9:0]  dy, x, y;
    logic [5:0]  num;
    logic [1:0]  pix;
    logic [10:0] addr;
    int          e;
    bk   = row[1];
    hits = 0;
    for (int k = 0; k < LINE_W; k++) begin
      addr = 11'(int'(bk) * LINE_W + k);
      exp_q.push_back({addr, 2'b00});
      model_buf[k] = 2'd0;
    end
    for (int i = NSPR - 1; i >= 0; i--) begin
      num = model_attr[i][25:20];
      y   = model_attr[i][19:10];
      x   = model_attr[i][9:0];
      dy  = row - y;
      if (model_attr[i][26] && dy < 10'd16) begin
        hits++;
        for (int c = 0; c < 8; c++) begin
          e   = int'(x[8:1]) + c;
          pix = rom_mem[num][dy[3:1]][c];
          if (!x[9] && e < LINE_W && pix != 2'd0) begin
            addr = 11'(int'(bk) * LINE_W + e);
            exp_q.push_back({addr, pix});
            model_buf[e] = pix;
          end
        end
      end
    end
  endtask

  task automatic write_attr(input int idx, input logic [26:0] d);
    bus.i_Attr_We   = 1'b1;
    bus.i_Attr_Addr = IW'(idx);
    bus.i_Attr_Data = d;
    tick();
    bus.i_Attr_We   = 1'b0;
    model_attr[idx] = d;
  endtask

  // mode 0: plain line; 1: extra Line_Start during DRAW; 2: reset during DRAW.
  task automatic run_line(input logic [9:0] row, input int mode);
    int   hits, busy_cnt, cyc, mism, base;
    logic acted;
    build_expect(row, hits);
    bus.i_Next_Row   = row;
    bus.i_Line_Start = 1'b1;
    tick();
    bus.i_Line_Start = 1'b0;
    busy_cnt = 0;
    cyc      = 0;
    acted    = 1'b0;
    while (bus.o_Busy && cyc < 2000) begin
      busy_cnt++;
      cyc++;
      if (mode == 1 && !acted && bus.o_Rom_Col == 3'd3) begin
        acted            = 1'b1;
        bus.i_Next_Row   = ~row;
        bus.i_Line_Start = 1'b1;
        tick();
        bus.i_Line_Start = 1'b0;
        chk("overrun_set", int'(bus.o_Overrun), 1);
      end else if (mode == 2 && !acted && bus.o_Rom_Col == 3'd3) begin
        acted = 1'b1;
        rst   = 1'b1;
        tick();
        rst   = 1'b0;
        exp_q.delete();
        for (int i = 0; i < NSPR; i++) model_attr[i] = '0;
        chk("reset_lr_we", int'(bus.o_Lr_We), 0);
        chk("reset_busy", int'(bus.o_Busy), 0);
        chk("reset_overrun", int'(bus.o_Overrun), 0);
        chk("reset_rom_col", int'(bus.o_Rom_Col), 0);
        break;
      end else begin
        tick();
      end
    end
    if (mode != 0) chk("mid_line_action_taken", int'(acted), 1);
    if (mode == 2) return;
    chk("busy_bound", int'(bus.o_Busy), 0);
    chk("busy_cycles", busy_cnt, LINE_W + NSPR + 9 * hits + 2);
    tick();
    chk("writes_left", exp_q.size(), 0);
    base = int'(row[1]) * LINE_W;
    mism = 0;
    for (int k = 0; k < LINE_W; k++)
      if (lr_mem[base + k] !== model_buf[k]) mism++;
    chk("line_buf_mismatch", mism, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] row;
    bus.i_Line_Start = 1'b0;
    bus.i_Next_Row   = '0;
    bus.i_Attr_We    = 1'b0;
    bus.i_Attr_Addr  = '0;
    bus.i_Attr_Data  = '0;
    for (int i = 0; i < NSPR; i++) model_attr[i] = '0;
    for (int i = 0; i < 2048; i++) lr_mem[i] = 2'd0;
    for (int n = 0; n < 64; n++)
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++)
          rom_mem[n][r][c] = 2'($urandom_range(0, 3));
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        rom_mem[40][r][c] = 2'd1;
        rom_mem[41][r][c] = 2'd3;
      end
    fork
      monitor();
    join_none

    rst = 1'b1;
    tick();
    tick();
    chk("rst_busy", int'(bus.o_Busy), 0);
    chk("rst_overrun", int'(bus.o_Overrun), 0);
    chk("rst_lr_we", int'(bus.o_Lr_We), 0);
    chk("rst_lr_addr", int'(bus.o_Lr_Addr), 0);
    chk("rst_lr_data", int'(bus.o_Lr_Data), 0);
    chk("rst_rom_sprite", int'(bus.o_Rom_Sprite), 0);
    chk("rst_rom_row", int'(bus.o_Rom_Row), 0);
    chk("rst_rom_col", int'(bus.o_Rom_Col), 0);
    rst = 1'b0;
    tick();

    run_line(10'd5, 0);

    write_attr(3, mk(1'b1, 6'd2, 10'd0, 10'd20));
    run_line(10'd6, 0);

    write_attr(3, '0);
    write_attr(0, mk(1'b1, 6'd40, 10'd0, 10'd40));
    write_attr(1, mk(1'b1, 6'd41, 10'd0, 10'd40));
    run_line(10'd2, 0);
    for (int k = 0; k < 8; k++)
      chk("top_sprite_pix", int'(lr_mem[LINE_W + 20 + k]), 1);

    write_attr(0, '0);
    write_attr(1, '0);
    write_attr(5, mk(1'b1, 6'd7, 10'd0, 10'd500));
    run_line(10'd9, 0);

    write_attr(0, mk(1'b1, 6'd40, 10'd8, 10'd100));
    run_line(10'd12, 1);
    run_line(10'd13, 0);
    chk("overrun_sticky", int'(bus.o_Overrun), 1);

    run_line(10'd14, 2);
    tick();
    run_line(10'd7, 0);

    for (int l = 0; l < 6; l++) begin
      row = 10'($urandom_range(0, 1023));
      for (int i = 0; i < NSPR; i++)
        write_attr(i, mk(1'($urandom_range(0, 3) != 0), 6'($urandom_range(0, 63)),
                         row - 10'($urandom_range(0, 24)), 10'($urandom_range(0, 1023))));
      run_line(row, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
